// File: rtl/data_switch_ctrl_pkg.sv
// data_switch_ctrl_pkg: shared sizing defaults, switch select encodings and
// controller state encoding for the data switch controller and its switch.
package data_switch_ctrl_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 16;
   localparam int unsigned CONV_UNITS_DEF = 8;
   localparam int unsigned SEL_W          = 2;

   // Switch select: window shifted by k words (3x3 beats), or by one word (1x1)
   localparam logic [SEL_W-1:0] SEL_K0  = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_K1  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_K2  = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_1X1 = SEL_W'(3);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // The last beat of a block is the third 3x3 beat or the only 1x1 beat
   function automatic logic is_final_sel(input logic [SEL_W-1:0] sel);
      return (sel == SEL_K2) || (sel == SEL_1X1);
   endfunction

endpackage

// File: rtl/data_switch.sv
// data_switch: selects a CONV_UNITS-word window out of a CONV_UNITS+2 word block.
//   held  : input block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sel   : SEL_K0/K1/K2 -> shift 0/1/2 words, SEL_1X1 -> shift 1 word
//   win_c : combinational window, word j = held word j+shift
module data_switch
   import data_switch_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CONV_UNITS = CONV_UNITS_DEF
) (
   input  logic [DATA_WIDTH*(CONV_UNITS+2)-1:0] held,
   input  logic [SEL_W-1:0]                     sel,
   output logic [DATA_WIDTH*CONV_UNITS-1:0]     win_c
);

   localparam int unsigned OUT_W = DATA_WIDTH * CONV_UNITS;

   // Three-way word-shift mux; 1x1 uses the centre (shift-by-one) column
   always_comb begin
      win_c = '0;
      unique case (sel)
         SEL_K0:          win_c = held[OUT_W-1:0];
         SEL_K1, SEL_1X1: win_c = held[OUT_W+DATA_WIDTH-1:DATA_WIDTH];
         SEL_K2:          win_c = held[OUT_W+2*DATA_WIDTH-1:2*DATA_WIDTH];
         default:         win_c = '0;
      endcase
   end

endmodule

// File: rtl/data_switch_ctrl.sv
// data_switch_ctrl: holds one input block and plays it out as one (1x1) or
// three (3x3) shifted windows through data_switch.
//   clk, rst                               : clock, async active-high reset
//   s_valid/s_ready/s_data/s_mode_3x3/s_last : input block handshake + sidebands
//   m_valid/m_ready/m_data/m_sel/m_last      : output beat handshake + window
module data_switch_ctrl
   import data_switch_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CONV_UNITS = CONV_UNITS_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [DATA_WIDTH*(CONV_UNITS+2)-1:0] s_data,
   input  logic                                 s_mode_3x3,
   input  logic                                 s_last,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic [DATA_WIDTH*CONV_UNITS-1:0]     m_data,
   output logic [SEL_W-1:0]                     m_sel,
   output logic                                 m_last
);

   localparam int unsigned IN_SIZE = CONV_UNITS + 2;

   state_e                        state;
   logic [DATA_WIDTH*IN_SIZE-1:0] held_data;
   logic                          held_last;
   logic [SEL_W-1:0]              sel_q;
   logic                          final_beat;
   logic                          beat_done;
   logic                          accept;

   assign final_beat = (state == ST_EMIT) && is_final_sel(sel_q);
   assign beat_done  = (state == ST_EMIT) && m_ready;
   // Ready on the final beat's handshake too, so blocks stream without a bubble
   assign s_ready    = !rst && ((state == ST_IDLE) || (final_beat && m_ready));
   assign accept     = s_valid && s_ready;

   assign m_valid = (state == ST_EMIT);
   assign m_sel   = sel_q;
   assign m_last  = final_beat && held_last;

   // Block holding register, beat select counter and IDLE/EMIT state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         held_data <= '0;
         held_last <= 1'b0;
         sel_q     <= SEL_K0;
      end else begin
         if (accept) begin
            state     <= ST_EMIT;
            held_data <= s_data;
            held_last <= s_last;
            // The select sequence fully encodes the kernel mode
            sel_q     <= s_mode_3x3 ? SEL_K0 : SEL_1X1;
         end else if (beat_done) begin
            if (final_beat) begin
               state <= ST_IDLE;
               sel_q <= SEL_K0;
            end else begin
               sel_q <= sel_q + SEL_W'(1);
            end
         end
      end
   end

   data_switch #(
      .DATA_WIDTH (DATA_WIDTH),
      .CONV_UNITS (CONV_UNITS)
   ) u_switch (
      .held  (held_data),
      .sel   (sel_q),
      .win_c (m_data)
   );

endmodule

// File: tb/tb_data_switch_ctrl.sv
// tb_data_switch_ctrl: directed scenario tasks plus a randomized run checked
// against a queue of expected beats built from the block/window rules.
module tb_data_switch_ctrl;

   localparam int DW = 16;
   localparam int CU = 8;
   localparam int IN = CU + 2;
   localparam int BW = DW * IN;
   localparam int OW = DW * CU;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_mode_3x3 = 1'b0;
   logic          s_last = 1'b0;
   logic          m_ready = 1'b0;
   logic [BW-1:0] s_data = '0;
   logic          s_ready;
   logic          m_valid;
   logic          m_last;
   logic [OW-1:0] m_data;
   logic [1:0]    m_sel;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [OW-1:0] data;
      logic [1:0]    sel;
      logic          last;
   } beat_t;

   beat_t exp_q[$];

   data_switch_ctrl #(.DATA_WIDTH(DW), .CONV_UNITS(CU)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_mode_3x3 (s_mode_3x3),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_sel      (m_sel),
      .m_last     (m_last)
   );

   always #5 clk = ~clk;

   // Block whose word i holds base+i
   function automatic logic [BW-1:0] ramp_block(input int base);
      logic [BW-1:0] b;
      for (int i = 0; i < IN; i++) b[i*DW +: DW] = DW'(base + i);
      return b;
   endfunction

   // Window whose word j holds first+j
   function automatic logic [OW-1:0] ramp_window(input int first);
      logic [OW-1:0] w;
      for (int j = 0; j < CU; j++) w[j*DW +: DW] = DW'(first + j);
      return w;
   endfunction

   // Window taken from an arbitrary block shifted by 'shift' words
   function automatic logic [OW-1:0] spec_window(input logic [BW-1:0] blk, input int shift);
      logic [DW-1:0] words [IN];
      logic [OW-1:0] w;
      for (int i = 0; i < IN; i++) words[i] = blk[i*DW +: DW];
      for (int j = 0; j < CU; j++) w[j*DW +: DW] = words[j + shift];
      return w;
   endfunction

   task automatic push_block(input logic [BW-1:0] blk, input logic mode, input logic last);
      if (mode) begin
         for (int k = 0; k < 3; k++)
            exp_q.push_back('{data: spec_window(blk, k), sel: 2'(k), last: last && (k == 2)});
      end else begin
         exp_q.push_back('{data: spec_window(blk, 1), sel: 2'd3, last: last});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel, m_last} !== 4'b0) begin
         n_err++; $display("FAIL reset_ctrl: got valid/sel/last %b/%0d/%b want 0/0/0", m_valid, m_sel, m_last);
      end
      n_cmp++;
      if (m_data !== '0) begin
         n_err++; $display("FAIL reset_data: got %h want 0", m_data);
      end
      n_cmp++;
      if (s_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_s_ready_held: got %b want 0", s_ready);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({s_ready, m_valid} !== 2'b10) begin
         n_err++; $display("FAIL reset_release: got s_ready/m_valid %b/%b want 1/0", s_ready, m_valid);
      end
   endtask

   task automatic test_3x3_basic();
      @(posedge clk); #1;
      s_data = ramp_block(1); s_mode_3x3 = 1'b1; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_ready, m_valid} !== 2'b10) begin
         n_err++; $display("FAIL basic_pre_accept: got s_ready/m_valid %b/%b want 1/0", s_ready, m_valid);
      end
      @(posedge clk); #1 s_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'(k), 1'b0, ramp_window(1 + k)}) begin
            n_err++;
            $display("FAIL basic_beat%0d: got v=%b sel=%0d last=%b data=%h want v=1 sel=%0d last=0 data=%h",
                     k, m_valid, m_sel, m_last, m_data, k, ramp_window(1 + k));
         end
      end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL basic_idle_after: got m_valid %b want 0", m_valid);
      end
   endtask

   task automatic test_1x1();
      @(posedge clk); #1;
      s_data = ramp_block(1); s_mode_3x3 = 1'b0; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      s_data = ramp_block(16'h40); s_mode_3x3 = 1'b1; s_last = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'd3, 1'b1, ramp_window(2)}) begin
         n_err++;
         $display("FAIL one_by_one_beat: got v=%b sel=%0d last=%b data=%h want v=1 sel=3 last=1 data=%h",
                  m_valid, m_sel, m_last, m_data, ramp_window(2));
      end
      n_cmp++;
      if (s_ready !== 1'b1) begin
         n_err++; $display("FAIL one_by_one_s_ready: got %b want 1", s_ready);
      end
      @(posedge clk); #1 s_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'(k), 1'b0, ramp_window(16'h40 + k)}) begin
            n_err++;
            $display("FAIL one_by_one_next%0d: got v=%b sel=%0d last=%b data=%h want v=1 sel=%0d last=0",
                     k, m_valid, m_sel, m_last, m_data, k);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL one_by_one_idle: got m_valid %b want 0", m_valid);
      end
   endtask

   task automatic test_stall();
      @(posedge clk); #1;
      s_data = ramp_block(16'h20); s_mode_3x3 = 1'b1; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel, m_data} !== {1'b1, 2'd0, ramp_window(16'h20)}) begin
         n_err++; $display("FAIL stall_beat0: got v=%b sel=%0d data=%h", m_valid, m_sel, m_data);
      end
      @(posedge clk); #1;
      m_ready = 1'b0;
      // Sideband changes and a pending block must not disturb the held block
      s_mode_3x3 = 1'b0; s_last = 1'b0; s_data = ramp_block(16'h99); s_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'd1, 1'b0, ramp_window(16'h21)}) begin
            n_err++;
            $display("FAIL stall_hold%0d: got v=%b sel=%0d last=%b data=%h want v=1 sel=1 last=0 data=%h",
                     c, m_valid, m_sel, m_last, m_data, ramp_window(16'h21));
         end
         n_cmp++;
         if (s_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_s_ready%0d: got %b want 0", c, s_ready);
         end
      end
      @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (m_sel !== 2'd1) begin
         n_err++; $display("FAIL stall_release_sel: got %0d want 1", m_sel);
      end
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'd2, 1'b1, ramp_window(16'h22)}) begin
         n_err++;
         $display("FAIL stall_beat2: got v=%b sel=%0d last=%b data=%h want v=1 sel=2 last=1",
                  m_valid, m_sel, m_last, m_data);
      end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL stall_idle: got m_valid %b want 0", m_valid);
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      s_data = ramp_block(16'h30); s_mode_3x3 = 1'b1; s_last = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      s_data = ramp_block(16'h50); s_last = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({m_valid, m_sel, m_last, m_data} !==
             {1'b1, 2'(i % 3), (i == 5), ramp_window(((i < 3) ? 16'h30 : 16'h50) + i % 3)}) begin
            n_err++;
            $display("FAIL b2b_beat%0d: got v=%b sel=%0d last=%b data=%h want v=1 sel=%0d last=%b",
                     i, m_valid, m_sel, m_last, m_data, i % 3, (i == 5));
         end
         n_cmp++;
         if (s_ready !== ((i % 3) == 2)) begin
            n_err++; $display("FAIL b2b_s_ready%0d: got %b want %b", i, s_ready, ((i % 3) == 2));
         end
         if (i == 2) begin
            @(posedge clk); #1 s_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_idle: got m_valid %b want 0", m_valid);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      s_data = ramp_block(16'h60); s_mode_3x3 = 1'b1; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel} !== {1'b1, 2'd0}) begin
         n_err++; $display("FAIL rstmid_beat0: got v=%b sel=%0d want v=1 sel=0", m_valid, m_sel);
      end
      @(posedge clk); #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({m_valid, m_sel, m_last, s_ready} !== 5'b0) begin
         n_err++; $display("FAIL rstmid_immediate: got v=%b sel=%0d last=%b s_ready=%b want all 0",
                           m_valid, m_sel, m_last, s_ready);
      end
      n_cmp++;
      if (m_data !== '0) begin
         n_err++; $display("FAIL rstmid_data: got %h want 0", m_data);
      end
      @(negedge clk);
      @(posedge clk); #3 rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (m_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_no_beats%0d: got m_valid %b want 0", c, m_valid);
         end
      end
      @(posedge clk); #1;
      s_data = ramp_block(16'h70); s_mode_3x3 = 1'b1; s_last = 1'b0; s_valid = 1'b1;
      @(posedge clk); #1 s_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({m_valid, m_sel, m_last, m_data} !== {1'b1, 2'd0, 1'b0, ramp_window(16'h70)}) begin
         n_err++; $display("FAIL rstmid_next_block: got v=%b sel=%0d last=%b data=%h want v=1 sel=0 last=0",
                           m_valid, m_sel, m_last, m_data);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_random();
      logic exp_valid;
      logic exp_sr;
      exp_q.delete();
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         if (c < 780) begin
            s_valid    = ($urandom_range(0, 2) != 0);
            s_mode_3x3 = 1'($urandom);
            s_last     = 1'($urandom);
            m_ready    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < IN; i++) s_data[i*DW +: DW] = DW'($urandom);
         end else begin
            s_valid = 1'b0;
            m_ready = 1'b1;
         end
         @(negedge clk);
         exp_valid = (exp_q.size() != 0);
         n_cmp++;
         if (m_valid !== exp_valid) begin
            n_err++; $display("FAIL rand_valid c%0d: got %b want %b", c, m_valid, exp_valid);
         end
         if (exp_valid) begin
            n_cmp++;
            if ({m_sel, m_last, m_data} !== {exp_q[0].sel, exp_q[0].last, exp_q[0].data}) begin
               n_err++;
               $display("FAIL rand_beat c%0d: got sel=%0d last=%b data=%h want sel=%0d last=%b data=%h",
                        c, m_sel, m_last, m_data, exp_q[0].sel, exp_q[0].last, exp_q[0].data);
            end
         end
         exp_sr = (exp_q.size() == 0) || ((exp_q.size() == 1) && m_ready);
         n_cmp++;
         if (s_ready !== exp_sr) begin
            n_err++; $display("FAIL rand_s_ready c%0d: got %b want %b", c, s_ready, exp_sr);
         end
         if (m_ready && (exp_q.size() != 0)) void'(exp_q.pop_front());
         if (s_valid && exp_sr) push_block(s_data, s_mode_3x3, s_last);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL rand_drain: got %0d beats outstanding want 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_3x3_basic();
      test_1x1();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
